// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: assembles dibit stream into N x N matrices A (row-wise) and B (column-wise)
module matrix_stream_loader #(
    parameter int N      = 32,
    parameter int ELEM_W = 8,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic                  eth_refclk,
    input  logic                  rst,
    input  logic                  rearm,
    input  logic                  axiiv,
    input  logic [1:0]            axiid,
    input  logic [IDX_W-1:0]      requested_a_row,
    input  logic [IDX_W-1:0]      requested_b_col,
    output logic [IDX_W-1:0]      addr_out,
    output logic [N*ELEM_W-1:0]   a_row_out,
    output logic [N*ELEM_W-1:0]   b_col_out,
    output logic                  a_loaded,
    output logic                  complete,
    output logic                  overrun
);
    localparam int DPE = ELEM_W / 2;
    localparam int DCW = DPE > 1 ? $clog2(DPE) : 1;
    typedef enum logic [1:0] {LOAD_A, LOAD_B, DONE} state_t;
    state_t state_q, state_d;
    logic [N*ELEM_W-1:0] a_q [N];
    logic [N*ELEM_W-1:0] b_q [N];
    logic [N*ELEM_W-1:0] a_row_q, b_col_q;
    logic [DCW-1:0] dib_q;
    logic [IDX_W-1:0] row_q, col_q, addr_q;
    logic [ELEM_W-1:0] part_q, elem;
    logic ovr_q, take, wr, col_last, row_last, last_elem, a_ok, b_ok;

    assign take      = axiiv && !rearm && state_q != DONE;
    assign wr        = take && dib_q == DCW'(DPE - 1);
    assign elem      = ELEM_W'({part_q, axiid});
    assign col_last  = col_q == IDX_W'(N - 1);
    assign row_last  = row_q == IDX_W'(N - 1);
    assign last_elem = wr && col_last && row_last;
    assign a_ok      = int'(requested_a_row) < N;
    assign b_ok      = int'(requested_b_col) < N;
    assign addr_out  = addr_q;
    assign a_row_out = a_row_q;
    assign b_col_out = b_col_q;
    assign a_loaded  = state_q != LOAD_A;
    assign complete  = state_q == DONE;
    assign overrun   = ovr_q;

    // next state: rearm restarts at A, the final element of a matrix advances
    always_comb begin
        state_d = rearm ? LOAD_A : last_elem ? (state_q == LOAD_A ? LOAD_B : DONE) : state_q;
    end

    // state register, dibit/element counters, partial element and sticky overrun
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            state_q <= LOAD_A;
            dib_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            part_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rearm) begin
                dib_q  <= '0;
                row_q  <= '0;
                col_q  <= '0;
                part_q <= '0;
                ovr_q  <= 1'b0;
            end else begin
                if (axiiv && state_q == DONE) ovr_q <= 1'b1;
                if (take) begin
                    part_q <= elem;
                    dib_q  <= wr ? '0 : dib_q + 1'b1;
                    if (wr) col_q <= col_last ? '0 : col_q + 1'b1;
                    if (wr && col_last) row_q <= row_last ? '0 : row_q + 1'b1;
                end
            end
        end
    end

    // storage: A kept row-wise, B transposed so a whole column is one word
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (wr) begin
            if (state_q == LOAD_A) a_q[row_q][col_q*ELEM_W +: ELEM_W] <= elem;
            else b_q[col_q][row_q*ELEM_W +: ELEM_W] <= elem;
        end
    end

    // registered read port; an out-of-range index reads as zero
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            addr_q  <= '0;
            a_row_q <= '0;
            b_col_q <= '0;
        end else begin
            addr_q  <= requested_a_row;
            a_row_q <= a_ok ? a_q[requested_a_row] : '0;
            b_col_q <= b_ok ? b_q[requested_b_col] : '0;
        end
    end
endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
Parametrised successor to the fixed 32x32 dibit matrix loader. It assembles elements from a 2-bit Ethernet-side stream (axiiv/axiid) and loads two N x N matrices back to back: A first, then B. Both are stored so that a full row of A and a full column of B can be read in one access. It sits between the Ethernet receive path and the systolic/MAC compute array, runs on a single clock, and adds a re-arm input, partial-load visibility and overrun detection.

Parameters:
N, 32, matrix dimension; must be at least 2.
ELEM_W, 8, element width in bits; must be even (ELEM_W/2 dibits per element).
IDX_W, $clog2(N), width of row/column indices.

Ports:
eth_refclk  input  1  sole clock
rst  input  1  synchronous, active-high reset
rearm  input  1  one-cycle pulse; restarts loading at A[0][0]
axiiv  input  1  dibit valid
axiid  input  2  dibit data
requested_a_row  input  IDX_W  A row to read
requested_b_col  input  IDX_W  B column to read
addr_out  output  IDX_W  registered copy of requested_a_row, aligned with a_row_out
a_row_out  output  N*ELEM_W  A[row][j] at bits [j*ELEM_W +: ELEM_W]
b_col_out  output  N*ELEM_W  B[r][col] at bits [r*ELEM_W +: ELEM_W]
a_loaded  output  1  all N*N elements of A captured
complete  output  1  A and B both fully captured
overrun  output  1  sticky: a valid dibit arrived while complete=1

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears all outputs, both storage arrays, the dibit counter, element counters and the A/B select.
  - rst takes priority over everything, including a load in progress; the next load starts at A[0][0].
- Dibit assembly:
  - A dibit is consumed only on cycles with axiiv=1.
  - Gaps with axiiv=0 are allowed anywhere, including mid-element; partial state is held across the gap.
  - Order is MSB first: the first dibit becomes bits [ELEM_W-1:ELEM_W-2].
- Element placement:
  - Elements arrive in row-major order (r, then c) with r, c in 0..N-1.
  - On the edge that captures an element's last dibit, the element is written to A[r][c] or B[r][c].
  - B is stored column-wise, i.e. transposed at write time.
  - A written element is visible to a read issued on the next cycle.
- Load state machine, states LOAD_A -> LOAD_B -> DONE:
  - LOAD_A -> LOAD_B: on the edge writing A[N-1][N-1]; a_loaded goes high from the next cycle.
  - LOAD_B -> DONE: on the edge writing B[N-1][N-1]; complete goes high from the next cycle.
  - DONE: dibits are ignored and storage is unchanged; the first valid dibit sets overrun.
- rearm:
  - Returns the FSM to LOAD_A and clears the counters, partial element, a_loaded, complete and overrun.
  - Storage contents are retained; they are overwritten as the new load proceeds.
  - rearm with axiiv=1 in the same cycle: rearm wins and the dibit is dropped.
  - rst with rearm: rst wins.
- Reads:
  - Single-cycle registered latency. requested_a_row / requested_b_col sampled at edge t appear on a_row_out / b_col_out / addr_out after edge t.
  - Reads are allowed in any state, including during a load; partially loaded data is returned as stored.
  - An index of N or more (when N is not a power of two) returns all zeros.
- Counters:
  - Column counter wraps N-1 -> 0 and then increments the row counter.
  - The row counter wrapping N-1 -> 0 triggers the state advance.
  - No counter ever exceeds N-1.

Test Plan:
- Identity pattern, default parameters: stream A with 0x00 on the diagonal and 0xFF elsewhere (4 dibits each), then B = A. Required: a_loaded high after 4096 valid dibits, complete high after 8192. Reading row 5 gives 0xFF in every byte except byte 5 = 0x00; column 5 identical.
- Transpose check, N=4, ELEM_W=8: load A = B = elements 0x00..0x0F row-major. Required: requested_b_col=1 gives b_col_out = {0x0D,0x09,0x05,0x01} (MSB byte first); requested_a_row=1 gives {0x07,0x06,0x05,0x04}; addr_out=1 one cycle after the request.
- Gapped stream, N=4: deassert axiiv for 3 cycles after every second dibit. Required: stored contents identical to the ungapped load.
- Overrun and rearm, N=4: after complete, send 1 extra valid dibit. Required: overrun=1 and storage unchanged. Then pulse rearm. Required: complete, a_loaded and overrun all 0, and a read of A row 0 still returns the old data.
- Mid-load reset, N=4: assert rst after 10 elements of A. Required: all outputs 0 the next cycle; a fresh full load then completes normally.
- Simultaneous rearm and dibit, N=4: rearm with axiiv=1, axiid=2'b11 in the same cycle, then a normal load. Required: the dropped dibit does not appear; A[0][0] equals the first post-rearm element.
